vga_pixel_fetch: RTL and testbench

Downstream consumer of the VGA timing generator: takes its `hcount`/`vcount`/`bright`/`hsync`/`vsync`, fetches pixels from a 320×240 8-bit framebuffer in synchronous RAM (each source pixel drawn 2×2 on the 640×480 raster), expands RGB332 to 24-bit colour, and drives the DAC and syncs with everything re-aligned. It also double-buffers the framebuffer, swapping front/back only at the start of vertical blank on a request from the CPU side.

---
 rtl/vga_pixel_fetch.sv | 136 +++++++++++++
 tb/tb_vga_pixel_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetch: counts -> framebuffer address -> RGB332 expand -> DAC, all outputs aligned at t+3.
// Optional front/back buffer swap at vblank start is enabled by defining VGA_FETCH_DOUBLE_BUFFER_EN.
module vga_pixel_fetch #(
  parameter int ADDR_W   = 18,
  parameter int FB_WORDS = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              bright,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              back_buf,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n
);

  logic              front_buf;
  logic [8:0]        pix_x;
  logic [8:0]        pix_y;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr_nxt;
  logic              bright_d1;
  logic              bright_d2;
  logic              hsync_d1;
  logic              vsync_d1;
  logic [7:0]        r_exp;
  logic [7:0]        g_exp;
  logic [7:0]        b_exp;

  assign pix_x = hcount[9:1];
  assign pix_y = vcount[9:1];
  assign base  = front_buf ? ADDR_W'(FB_WORDS) : '0;

  // y*320 as two shifts; fits ADDR_W for every count the timing generator produces
  assign addr_nxt = base + (ADDR_W'(pix_y) << 8) + (ADDR_W'(pix_y) << 6) + ADDR_W'(pix_x);

  assign r_exp = {mem_data[7:5], mem_data[7:5], mem_data[7:6]};
  assign g_exp = {mem_data[4:2], mem_data[4:2], mem_data[4:3]};
  assign b_exp = {4{mem_data[1:0]}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      bright_d1   <= 1'b0;
      bright_d2   <= 1'b0;
      hsync_d1    <= 1'b1;
      vsync_d1    <= 1'b1;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_blank_n <= 1'b0;
    end else begin
      mem_addr    <= addr_nxt;
      bright_d1   <= bright;
      bright_d2   <= bright_d1;
      // syncs already lag the counts by one, so two stages land them at t+3
      hsync_d1    <= hsync_in;
      vsync_d1    <= vsync_in;
      vga_hsync   <= hsync_d1;
      vga_vsync   <= vsync_d1;
      vga_r       <= bright_d2 ? r_exp : '0;
      vga_g       <= bright_d2 ? g_exp : '0;
      vga_b       <= bright_d2 ? b_exp : '0;
      vga_blank_n <= bright_d2;
    end
  end

`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
  // state   | meaning
  // IDLE    | no swap requested
  // PENDING | swap requested, waiting for vblank start (hcount==0, vcount==480)
  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t state;
  swap_state_t state_nxt;
  logic        req_q;
  logic        swap_rise;
  logic        vblank_start;
  logic        front_nxt;
  logic        ack_nxt;

  assign swap_rise    = swap_req & ~req_q;
  assign vblank_start = (hcount == 10'd0) && (vcount == 10'd480);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      front_buf <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= swap_req;
      front_buf <= front_nxt;
      swap_ack  <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    front_nxt = front_buf;
    ack_nxt   = 1'b0;
    case (state)
      IDLE:    if (swap_rise) state_nxt = PENDING;
      PENDING: if (vblank_start) begin
                 state_nxt = IDLE;
                 front_nxt = ~front_buf;
                 ack_nxt   = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  assign back_buf = ~front_buf;
`else
  logic [2:0] unused_in;

  assign front_buf = 1'b0;
  assign swap_ack  = 1'b0;
  assign back_buf  = 1'b0;
  assign unused_in = {swap_req, hcount[0], vcount[0]};
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: address map, colour/latency, sync alignment, buffer swap.
// Swap checks run when VGA_FETCH_DOUBLE_BUFFER_EN is defined; otherwise the fixed-buffer behaviour is checked.
module tb_vga_pixel_fetch;

  logic        clk;
  logic        reset;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        bright;
  logic        hsync_in;
  logic        vsync_in;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic        swap_req;
  logic        swap_ack;
  logic        back_buf;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;

  int n_checks = 0;
  int n_fail   = 0;

  vga_pixel_fetch #(.ADDR_W(18), .FB_WORDS(76800)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .bright(bright),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem_addr(mem_addr), .mem_data(mem_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .back_buf(back_buf),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // address 0 holds E3, address 1 holds E2
  function automatic logic [7:0] pix(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'hE3;
  endfunction

  always @(posedge clk) mem_data <= pix(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle of the timing generator; its syncs are registered from the previous counts
  task automatic step(input int h, input int v);
    @(posedge clk);
    #1;
    hsync_in = !(hcount >= 10'd656 && hcount < 10'd752);
    vsync_in = !(vcount >= 10'd490 && vcount < 10'd492);
    hcount   = h[9:0];
    vcount   = v[9:0];
    bright   = (h < 640) && (v < 480);
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    hcount   = 10'd700;
    vcount   = 10'd500;
    bright   = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int lows;
    logic obs [0:3];
    swap_req = 1'b0;
    reset_dut();

    check("rst_hsync", vga_hsync, 1);
    check("rst_vsync", vga_vsync, 1);
    check("rst_blank_n", vga_blank_n, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_ack", swap_ack, 0);
    check("rst_addr", mem_addr, 0);
`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
    check("rst_back_buf", back_buf, 1);
`else
    check("rst_back_buf", back_buf, 0);
`endif

    // address map
    step(2, 3);
    step(0, 500);
    check("addr_2_3", mem_addr, 321);
    step(639, 479);
    step(0, 500);
    check("addr_639_479", mem_addr, 76799);

    // colour expansion and 3-cycle latency
    step(0, 0);
    step(2, 0);
    step(640, 0);
    step(641, 0);
    check("rgb_e3", {vga_r, vga_g, vga_b}, 24'hFF00FF);
    check("blank_e3", vga_blank_n, 1);
    step(642, 0);
    check("rgb_e2", {vga_r, vga_g, vga_b}, 24'hFF00AA);
    check("blank_e2", vga_blank_n, 1);
    step(643, 0);
    check("rgb_h640", {vga_r, vga_g, vga_b}, 0);
    check("blank_h640", vga_blank_n, 0);

    // hsync: output after presenting h reflects h-3
    lows = 0;
    for (int h = 650; h <= 760; h++) begin
      step(h, 10);
      if (vga_hsync == 1'b0) lows++;
      if (h == 658) check("hsync_pre", vga_hsync, 1);
      if (h == 659) check("hsync_fall", vga_hsync, 0);
      if (h == 754) check("hsync_last", vga_hsync, 0);
      if (h == 755) check("hsync_rise", vga_hsync, 1);
    end
    check("hsync_width", lows, 96);

    // vsync over the line boundary
    for (int v = 486; v <= 497; v++) begin
      step(0, v);
      if (v >= 492 && v <= 495) obs[v - 492] = vga_vsync;
    end
    check("vsync_489", obs[0], 1);
    check("vsync_490", obs[1], 0);
    check("vsync_491", obs[2], 0);
    check("vsync_492", obs[3], 1);

`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
    // basic swap
    step(0, 100);
    swap_req = 1'b1;
    step(1, 100);
    swap_req = 1'b0;
    step(2, 100);
    step(799, 479);
    step(0, 480);
    check("swap_ack_early", swap_ack, 0);
    step(1, 480);
    check("swap_ack", swap_ack, 1);
    check("swap_back_buf", back_buf, 0);
    step(2, 480);
    check("swap_ack_single", swap_ack, 0);
    step(0, 0);
    step(1, 0);
    check("addr_front1", mem_addr, 76800);

    // second rising edge while pending
    step(0, 200);
    swap_req = 1'b1;
    step(1, 200);
    swap_req = 1'b0;
    step(2, 200);
    swap_req = 1'b1;
    step(3, 200);
    swap_req = 1'b0;
    step(0, 480);
    step(1, 480);
    check("dbl_ack", swap_ack, 1);
    check("dbl_back_buf", back_buf, 1);
    step(0, 10);
    step(0, 480);
    step(1, 480);
    check("dbl_no_second", swap_ack, 0);
    check("dbl_back_hold", back_buf, 1);

    // rising edge exactly at vblank start is deferred a frame
    step(0, 480);
    swap_req = 1'b1;
    step(1, 480);
    swap_req = 1'b0;
    check("vbs_no_ack", swap_ack, 0);
    step(2, 480);
    check("vbs_back_hold", back_buf, 1);
    step(0, 100);
    step(0, 480);
    step(1, 480);
    check("vbs_next_frame", swap_ack, 1);
    check("vbs_back_buf", back_buf, 0);

    // reset while pending loses the request
    step(0, 100);
    swap_req = 1'b1;
    step(1, 100);
    swap_req = 1'b0;
    reset = 1'b1;
    #1;
    check("rstp_back_buf", back_buf, 1);
    check("rstp_ack", swap_ack, 0);
    reset_dut();
    step(0, 480);
    step(1, 480);
    check("rstp_no_ack", swap_ack, 0);
    step(0, 0);
    step(1, 0);
    check("rstp_addr", mem_addr, 0);
`else
    // fixed buffer: requests are ignored
    step(0, 100);
    swap_req = 1'b1;
    step(1, 100);
    swap_req = 1'b0;
    step(0, 480);
    step(1, 480);
    check("nodb_ack", swap_ack, 0);
    check("nodb_back_buf", back_buf, 0);
    step(0, 0);
    step(1, 0);
    check("nodb_addr", mem_addr, 0);
    step(639, 479);
    step(0, 500);
    check("nodb_addr_max", mem_addr < 18'd76800, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
